beat_monitor: RTL
=================

Name: beat_monitor

Overview:
- Receiver side of the beat-pulse interface. It watches a one-cycle `beat_in` strobe, such as the 32-cycle beat enable, and checks that the strobe arrives with the expected period.
- It reports lock status, flags early and late beats, and keeps a saturating error count.
- It sits beside the beat generator as a self-check for the timing chain. It also guards any downstream block that consumes the beat.

Parameters:
- PERIOD, 32: expected beat-to-beat gap, in clock cycles (≥4).
- TOL, 0: allowed deviation, ± cycles (TOL < PERIOD/2).
- LOCK_COUNT, 4: number of consecutive good gaps required to declare lock (1..15).
- ERRW, 8: width of the error counter.

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- rst, input, 1: reset rst, synchronous, active-low.
- enable, input, 1: monitor enable; low forces IDLE.
- beat_in, input, 1: beat strobe; one cycle per beat.
- clr_err, input, 1: synchronous clear of err_count.
- locked, output, 1: high while in LOCKED.
- err_early, output, 1: one-cycle pulse on an early beat.
- err_late, output, 1: one-cycle pulse on a missing or late beat.
- err_count, output, ERRW: saturating total of early plus late errors.

Behaviour:
- Localparam CW = $clog2(PERIOD+TOL+2). It is the width of the gap counter `cnt`.
- gap counter:
  - On a beat cycle, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 2^CW-1.
  - The measured gap is the value of cnt in the beat cycle. For beats at t and t+32, gap = 32.
- Gap classification:
  - good: PERIOD-TOL ≤ gap ≤ PERIOD+TOL.
  - early: gap < PERIOD-TOL.
  - late: cnt reaches PERIOD+TOL+1 with no beat. This is detected in that cycle, without waiting for the beat.
- State machine:
  - IDLE:
    - Entered on reset or when enable=0. cnt and good_cnt are held at 0.
    - enable=1 → SEARCH.
  - SEARCH:
    - Waits for a reference beat. No late check is made.
    - beat → TRACK, good_cnt=0.
  - TRACK:
    - good beat → good_cnt++. If good_cnt reaches LOCK_COUNT → LOCKED.
    - early beat → err_early; stay in TRACK with good_cnt=0. The early beat becomes the new reference.
    - late → err_late; go to SEARCH.
  - LOCKED:
    - good beat → stay.
    - early beat → err_early; go to TRACK with good_cnt=0.
    - late → err_late; go to SEARCH.
- enable=0 in any state → IDLE on the next edge.
  - locked drops.
  - err_count is retained.
  - An error detected in the same cycle is suppressed.
- Latency: all outputs are registered.
  - err_early and err_late assert in the cycle after the triggering beat or late detection.
  - locked rises in the cycle after the LOCK_COUNT-th good beat.
  - locked falls in the cycle after the error.
- err_count:
  - Increments by 1 per error pulse and saturates at 2^ERRW-1.
  - If clr_err coincides with an error, clr_err wins and the result is 0.
  - err_early and err_late are mutually exclusive by construction.
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - cnt=0, good_cnt=0.
  - locked=0, err_early=0, err_late=0, err_count=0.
  - Reset overrides all other inputs, including mid-LOCKED.
- beat_in held high for several cycles: each high cycle counts as a beat. The second cycle has gap=1 and is flagged early when PERIOD-TOL > 1.

Optional Feature:
- Macro: BEAT_MONITOR_GAP_EN.
- Defined:
  - Adds output port last_gap, width CW.
  - last_gap loads the measured gap on every beat in TRACK or LOCKED.
  - On late detection it loads 2^CW-1.
  - Reset value 0.
  - It updates in the same cycle the error or good result registers.
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Package beat_pkg:
  - State encoding constants: BM_IDLE=2'd0, BM_SEARCH=2'd1, BM_TRACK=2'd2, BM_LOCKED=2'd3.
  - Default BEAT_PERIOD=32, shared with the generator.
- Sub-module gap_counter:
  - Saturating CW-bit cycle counter with synchronous restart-to-1 and hold-at-0 inputs.
- The FSM and the error counter stay in beat_monitor.
- All state registers use the team's dffr flop. Its reset input is driven from the inverted active-low rst.

Test Plan (PERIOD=32, TOL=1, LOCK_COUNT=4, ERRW=8):
- Lock-in: enable=1, then beats every 32 cycles → locked=1 in the cycle after the 5th beat (1 reference + 4 good). No error pulses; err_count=0.
- Early beat: while locked, one beat arrives at gap 28 → err_early pulses for exactly one cycle after that beat. locked=0 next cycle; err_count=1. After four more gaps of 32, locked=1 again.
- Missing beat: while locked, one beat is dropped → cnt reaches 34 and err_late pulses in the following cycle. locked=0 and state=SEARCH. Resuming beats relocks after 5 beats.
- Tolerance edges: gaps 31 and 33 keep lock with no error. Gap 30 gives err_early. A 34th cycle with no beat gives err_late.
- Counter saturation and clear:
  - 300 consecutive early beats (gap 5) → err_count saturates at 255.
  - clr_err asserted in the same cycle as an error → err_count=0.
- Reset and enable:
  - rst=0 for one cycle while locked → next cycle locked=0, err_count=0, state IDLE.
  - Dropping enable while locked → locked=0 next cycle and err_count is retained.

Source files
------------

// File: rtl/beat_pkg.sv
`default_nettype none
// ============================================================================
// beat_pkg
// Shared beat-interface constants: default beat period and monitor state codes.
// Revision: 1.0
// ============================================================================
package beat_pkg;

  localparam int BEAT_PERIOD = 32;

  localparam logic [1:0] BM_IDLE   = 2'd0;
  localparam logic [1:0] BM_SEARCH = 2'd1;
  localparam logic [1:0] BM_TRACK  = 2'd2;
  localparam logic [1:0] BM_LOCKED = 2'd3;

  typedef struct packed {
    logic early;
    logic late;
  } beat_err_t;

endpackage
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
// dffr
// W-bit D flop with synchronous active-high clear to zero.
// Revision: 1.0
// ============================================================================
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule
`default_nettype wire

// File: rtl/gap_counter.sv
`default_nettype none
// ============================================================================
// gap_counter
// Saturating CW-bit cycle counter with synchronous restart-to-1 and hold-at-0.
// Revision: 1.0
// ============================================================================
module gap_counter #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          restart,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          w_rst_h;
  logic [CW-1:0] w_cnt_nxt;

  assign w_rst_h = ~rst;

  // hold wins over restart so an idle monitor ignores stray beats
  always_comb begin
    w_cnt_nxt = cnt;
    if (hold)                w_cnt_nxt = '0;
    else if (restart)        w_cnt_nxt = CW'(1);
    else if (cnt != CNT_MAX) w_cnt_nxt = cnt + CW'(1);
  end

  dffr #(.W(CW)) u_cnt (
    .clk (clk),
    .rst (w_rst_h),
    .d   (w_cnt_nxt),
    .q   (cnt)
  );

endmodule
`default_nettype wire

// File: rtl/beat_monitor.sv
`default_nettype none
// ============================================================================
// beat_monitor
// Checks beat strobe period; reports lock, early/late pulses, error count.
// Optional last_gap output when BEAT_MONITOR_GAP_EN is defined.
// Revision: 1.0
// ============================================================================
module beat_monitor
  import beat_pkg::*;
#(
  parameter int PERIOD     = BEAT_PERIOD,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int ERRW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            beat_in,
  input  logic            clr_err,
  output logic            locked,
  output logic            err_early,
  output logic            err_late,
  output logic [ERRW-1:0] err_count
`ifdef BEAT_MONITOR_GAP_EN
  ,
  output logic [$clog2(PERIOD+TOL+2)-1:0] last_gap
`endif
);

  localparam int CW = $clog2(PERIOD+TOL+2);
  localparam logic [CW-1:0]   GAP_LO   = CW'(PERIOD - TOL);
  localparam logic [CW-1:0]   GAP_LATE = CW'(PERIOD + TOL + 1);
  localparam logic [3:0]      LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;

  logic            w_rst_h;
  logic [CW-1:0]   w_cnt;
  logic            w_hold;
  logic            w_tracking;
  logic            w_late;
  logic            w_early;
  logic            w_good;
  beat_err_t       w_err;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [3:0]      r_good_cnt;
  logic [3:0]      w_good_nxt;
  logic            w_locked_nxt;
  logic [ERRW-1:0] w_err_count_nxt;

  assign w_rst_h = ~rst;
  assign w_hold  = ~enable | (r_state == BM_IDLE);

  gap_counter #(.CW(CW)) u_gap_counter (
    .clk     (clk),
    .rst     (rst),
    .hold    (w_hold),
    .restart (beat_in),
    .cnt     (w_cnt)
  );

  // late is checked without waiting for a beat; it outranks a beat arriving in the same cycle
  assign w_tracking = (r_state == BM_TRACK) | (r_state == BM_LOCKED);
  assign w_late     = w_tracking & (w_cnt >= GAP_LATE);
  assign w_early    = w_tracking & beat_in & ~w_late & (w_cnt < GAP_LO);
  assign w_good     = w_tracking & beat_in & ~w_late & ~w_early;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    if (!enable) begin
      w_state_nxt = BM_IDLE;
      w_good_nxt  = '0;
    end else begin
      case (r_state)
        BM_IDLE: begin
          w_state_nxt = BM_SEARCH;
          w_good_nxt  = '0;
        end
        BM_SEARCH: begin
          if (beat_in) begin
            w_state_nxt = BM_TRACK;
            w_good_nxt  = '0;
          end
        end
        BM_TRACK: begin
          if (w_late) begin
            w_state_nxt = BM_SEARCH;
          end else if (w_early) begin
            w_good_nxt = '0;
          end else if (w_good) begin
            w_good_nxt = r_good_cnt + 4'd1;
            if (r_good_cnt + 4'd1 == LOCK_N) w_state_nxt = BM_LOCKED;
          end
        end
        BM_LOCKED: begin
          if (w_late) begin
            w_state_nxt = BM_SEARCH;
          end else if (w_early) begin
            w_state_nxt = BM_TRACK;
            w_good_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = BM_IDLE;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  // errors seen while enable is dropping are discarded
  assign w_err.early  = enable & w_early;
  assign w_err.late   = enable & w_late;
  assign w_locked_nxt = (w_state_nxt == BM_LOCKED);

  always_comb begin
    w_err_count_nxt = err_count;
    if (clr_err)
      w_err_count_nxt = '0;
    else if ((w_err.early | w_err.late) && (err_count != ERR_MAX))
      w_err_count_nxt = err_count + ERRW'(1);
  end

  dffr #(.W(2)) u_state (
    .clk (clk), .rst (w_rst_h), .d (w_state_nxt), .q (r_state)
  );

  dffr #(.W(4)) u_good_cnt (
    .clk (clk), .rst (w_rst_h), .d (w_good_nxt), .q (r_good_cnt)
  );

  dffr #(.W(1)) u_locked (
    .clk (clk), .rst (w_rst_h), .d (w_locked_nxt), .q (locked)
  );

  dffr #(.W(1)) u_err_early (
    .clk (clk), .rst (w_rst_h), .d (w_err.early), .q (err_early)
  );

  dffr #(.W(1)) u_err_late (
    .clk (clk), .rst (w_rst_h), .d (w_err.late), .q (err_late)
  );

  dffr #(.W(ERRW)) u_err_count (
    .clk (clk), .rst (w_rst_h), .d (w_err_count_nxt), .q (err_count)
  );

`ifdef BEAT_MONITOR_GAP_EN
  logic [CW-1:0] w_last_gap_nxt;

  // a late result is marked with the all-ones code
  always_comb begin
    w_last_gap_nxt = last_gap;
    if (w_err.late)
      w_last_gap_nxt = '1;
    else if (enable && w_tracking && beat_in)
      w_last_gap_nxt = w_cnt;
  end

  dffr #(.W(CW)) u_last_gap (
    .clk (clk), .rst (w_rst_h), .d (w_last_gap_nxt), .q (last_gap)
  );
`endif

endmodule
`default_nettype wire
